// File: rtl/vend_pkg.sv
// Shared vending types and constants: coin event encoding, coin values and
// helpers that turn per-line debounced rise flags into a coin event.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_code_t;

  localparam int unsigned COIN_5_VALUE   = 32'd5;
  localparam int unsigned COIN_10_VALUE  = 32'd10;
  localparam int unsigned COIN_25_VALUE  = 32'd25;
  localparam int unsigned NUM_COIN_LINES = 32'd3;

  // Number of lines rising on the same edge (0..3).
  function automatic logic [1:0] rise_count(input logic [2:0] rise);
    return {1'b0, rise[0]} + {1'b0, rise[1]} + {1'b0, rise[2]};
  endfunction

  // Event code for a single rising line; anything else is not a coin.
  function automatic coin_code_t rise_to_code(input logic [2:0] rise);
    case (rise)
      3'b001:  return COIN_5;
      3'b010:  return COIN_10;
      3'b100:  return COIN_25;
      default: return COIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_debounce.sv
// One coin sensor line: 2-flop synchroniser followed by a counter-based
// debouncer; rise flags the edge on which the debounced level goes 0->1.
module vend_coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             s1_r;
  logic             s2_r;
  logic             db_r;
  logic [CNT_W-1:0] cnt_r;

  assign db   = db_r;
  assign rise = s2_r & ~db_r & (cnt_r == CNT_MAX);

  // Synchronise the raw line and let db follow only after a stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      db_r  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
      if (s2_r == db_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        db_r  <= s2_r;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vend_coin_acceptor.sv
// Coin acceptor front end: three debounced sensor lines feed a 2-entry event
// queue drained over valid/ready, with sticky jam and overflow flags.
module vend_coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] coin_raw,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  input  logic       coin_ready,
  input  logic       err_clr,
  output logic       jam,
  output logic       overflow
);

  logic [NUM_COIN_LINES-1:0] db_s;
  logic [NUM_COIN_LINES-1:0] rise_s;

  for (genvar g = 0; g < NUM_COIN_LINES; g++) begin : g_line
    vend_coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (coin_raw[g]),
      .db   (db_s[g]),
      .rise (rise_s[g])
    );
  end

  // Entries hold COIN_NONE when unoccupied so the head doubles as coin_code.
  coin_code_t e0_r, e1_r, e0_s, e1_s, push_code_s;
  logic [1:0] cnt_r, cnt_s, rise_n_s;
  logic       valid_r, jam_r, ovf_r, jam_s, ovf_s;
  logic       push_s, pop_s, drop_s;

  assign coin_valid = valid_r;
  assign coin_code  = e0_r;
  assign jam        = jam_r;
  assign overflow   = ovf_r;

  // Next queue occupancy/contents and error flags from this edge's rises.
  always_comb begin
    rise_n_s    = rise_count(rise_s);
    push_code_s = rise_to_code(rise_s);
    push_s      = (rise_n_s == 2'd1) & ~jam_r;
    pop_s       = valid_r & coin_ready;
    drop_s      = 1'b0;
    e0_s        = e0_r;
    e1_s        = e1_r;
    cnt_s       = cnt_r;
    case (cnt_r)
      2'd0: begin
        if (push_s) begin
          e0_s  = push_code_s;
          cnt_s = 2'd1;
        end else begin
          cnt_s = 2'd0;
        end
      end
      2'd1: begin
        if (pop_s && push_s) begin
          e0_s = push_code_s;
        end else if (pop_s) begin
          e0_s  = COIN_NONE;
          cnt_s = 2'd0;
        end else if (push_s) begin
          e1_s  = push_code_s;
          cnt_s = 2'd2;
        end else begin
          cnt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s && push_s) begin
          e0_s = e1_r;
          e1_s = push_code_s;
        end else if (pop_s) begin
          e0_s  = e1_r;
          e1_s  = COIN_NONE;
          cnt_s = 2'd1;
        end else if (push_s) begin
          drop_s = 1'b1;
        end else begin
          cnt_s = 2'd2;
        end
      end
      default: begin
        e0_s  = COIN_NONE;
        e1_s  = COIN_NONE;
        cnt_s = 2'd0;
      end
    endcase

    // A clear only releases jam once every line has settled low.
    if (jam_r) begin
      if (err_clr && (db_s == 3'b000)) begin
        jam_s = 1'b0;
      end else begin
        jam_s = 1'b1;
      end
    end else if (rise_n_s >= 2'd2) begin
      jam_s = 1'b1;
    end else begin
      jam_s = 1'b0;
    end

    if (err_clr) begin
      ovf_s = 1'b0;
    end else if (drop_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Queue and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_r    <= COIN_NONE;
      e1_r    <= COIN_NONE;
      cnt_r   <= 2'd0;
      valid_r <= 1'b0;
      jam_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      e0_r    <= e0_s;
      e1_r    <= e1_s;
      cnt_r   <= cnt_s;
      valid_r <= (cnt_s != 2'd0);
      jam_r   <= jam_s;
      ovf_r   <= ovf_s;
    end
  end

endmodule

// File: tb/tb_vend_coin_acceptor.sv
// Directed bench for vend_coin_acceptor: a behavioural model (delay line,
// stable-run counting, queue) is compared every cycle, plus literal checks.
module tb_vend_coin_acceptor;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] coin_raw;
  logic       coin_ready;
  logic       err_clr;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       jam;
  logic       overflow;

  always #5 clk = ~clk;

  vend_coin_acceptor #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin_raw  (coin_raw),
    .coin_valid(coin_valid),
    .coin_code (coin_code),
    .coin_ready(coin_ready),
    .err_clr   (err_clr),
    .jam       (jam),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sensor value seen two edges late, db follows after D
  // consecutive disagreeing edges; events go into a bounded FIFO.
  logic       m_p1[3];
  logic       m_p2[3];
  logic       m_db[3];
  int         m_run[3];
  logic       m_jam;
  logic       m_ovf;
  logic [1:0] m_q[$];

  function automatic logic m_valid();
    return m_q.size() != 0;
  endfunction

  function automatic logic [1:0] m_head();
    return (m_q.size() != 0) ? m_q[0] : 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_p1[i] = 1'b0; m_p2[i] = 1'b0; m_db[i] = 1'b0; m_run[i] = 0;
    end
    m_jam = 1'b0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    int   rises;
    int   line;
    logic all0;
    logic seen;
    logic pop;
    logic push;
    rises = 0; line = 0; all0 = 1'b1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) if (m_db[i]) all0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = m_p2[i];
      m_p2[i] = m_p1[i];
      m_p1[i] = coin_raw[i];
      if (seen != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i] = seen;
          m_run[i] = 0;
          if (seen) begin rises++; line = i; end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    pop  = (m_q.size() != 0) && coin_ready;
    push = (rises == 1) && !m_jam;
    if (m_jam) begin
      if (err_clr && all0) m_jam = 1'b0;
    end else if (rises >= 2) begin
      m_jam = 1'b1;
    end
    if (err_clr) m_ovf = 1'b0;
    else if (push && m_q.size() == 2 && !pop) m_ovf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < 2) m_q.push_back(2'(line + 1));
  endtask

  // Advance n cycles; the model steps between the compare and the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic insert(input logic [2:0] bits);
    coin_raw = bits;
    tick(6);
    coin_raw = 3'b000;
    tick(6);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cmp_valid", {3'b000, coin_valid}, {3'b000, m_valid()});
    check("cmp_code",  {2'b00, coin_code},   {2'b00, m_head()});
    check("cmp_jam",   {3'b000, jam},        {3'b000, m_jam});
    check("cmp_ovf",   {3'b000, overflow},   {3'b000, m_ovf});
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; coin_raw = 3'b000; coin_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    tick(3);
    check("reset_outs", {coin_valid, coin_code, jam | overflow}, 4'b0000);
    rst_n = 1'b1;
    tick(2);

    // Single 5c coin: event appears exactly at edge 6, held until popped.
    coin_raw = 3'b001;
    tick(5);
    check("lat_edge5_valid", {3'b000, coin_valid}, 4'h0);
    tick(1);
    check("lat_edge6_valid", {3'b000, coin_valid}, 4'h1);
    check("lat_edge6_code", {2'b00, coin_code}, 4'h1);
    check("model_pin_head", {2'b00, m_head()}, 4'h1);
    tick(4);
    check("hold_code", {2'b00, coin_code}, 4'h1);
    coin_ready = 1'b1;
    tick(1);
    coin_ready = 1'b0;
    check("pop_empty", {3'b000, coin_valid}, 4'h0);
    coin_raw = 3'b000;
    tick(8);

    // Glitch of 3 cycles is rejected; a 10-cycle hold gives one 25c event.
    coin_raw = 3'b100;
    tick(3);
    coin_raw = 3'b000;
    tick(8);
    check("glitch_none", {3'b000, coin_valid}, 4'h0);
    coin_raw = 3'b100;
    tick(10);
    check("c25_code", {2'b00, coin_code}, 4'h3);
    coin_ready = 1'b1;
    tick(1);
    check("c25_single", {3'b000, coin_valid}, 4'h0);
    coin_ready = 1'b0;
    coin_raw = 3'b000;
    tick(8);

    // Jam: clear refused while lines are high, accepted once all settle low.
    coin_raw = 3'b011;
    tick(6);
    check("jam_set", {2'b00, jam, coin_valid}, 4'b0010);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("jam_hold", {3'b000, jam}, 4'h1);
    coin_raw = 3'b000;
    tick(6);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("jam_clear", {3'b000, jam}, 4'h0);
    tick(2);

    // Overflow: third coin into a full queue is dropped.
    insert(3'b001);
    insert(3'b010);
    insert(3'b100);
    check("ovf_set", {3'b000, overflow}, 4'h1);
    check("ovf_head", {2'b00, coin_code}, 4'h1);
    check("model_pin_depth", m_q.size(), 2);
    coin_ready = 1'b1;
    tick(1);
    check("ovf_pop1", {1'b0, coin_valid, coin_code}, 4'b0110);
    tick(1);
    check("ovf_pop2", {3'b000, coin_valid}, 4'h0);
    coin_ready = 1'b0;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ovf_clear", {3'b000, overflow}, 4'h0);

    // Full queue with push and pop on the same edge.
    insert(3'b001);
    insert(3'b010);
    coin_raw = 3'b100;
    tick(5);
    coin_ready = 1'b1;
    tick(1);
    coin_ready = 1'b0;
    coin_raw = 3'b000;
    check("full_pp_head", {1'b0, coin_valid, coin_code}, 4'b0110);
    check("full_pp_ovf", {3'b000, overflow}, 4'h0);
    coin_ready = 1'b1;
    tick(1);
    check("full_pp_next", {1'b0, coin_valid, coin_code}, 4'b0111);
    tick(1);
    check("full_pp_empty", {3'b000, coin_valid}, 4'h0);
    coin_ready = 1'b0;
    tick(6);

    // One entry with push and pop on the same edge: new entry is the head.
    insert(3'b001);
    coin_raw = 3'b010;
    tick(5);
    coin_ready = 1'b1;
    tick(1);
    coin_ready = 1'b0;
    coin_raw = 3'b000;
    check("one_pp_head", {1'b0, coin_valid, coin_code}, 4'b0110);
    coin_ready = 1'b1;
    tick(1);
    coin_ready = 1'b0;
    check("one_pp_empty", {3'b000, coin_valid}, 4'h0);
    tick(6);

    // Asynchronous reset mid-debounce with one queued entry.
    insert(3'b100);
    check("pre_rst_valid", {3'b000, coin_valid}, 4'h1);
    coin_raw = 3'b001;
    tick(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", {coin_valid, coin_code, jam | overflow}, 4'b0000);
    coin_raw = 3'b000;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("no_spurious", {3'b000, coin_valid}, 4'h0);
    coin_raw = 3'b001;
    tick(6);
    check("fresh_rise", {1'b0, coin_valid, coin_code}, 4'b0101);
    coin_raw = 3'b000;
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
